// File: rtl/srsc_recover_pipe.sv
// Dehaze radiance recovery J = clamp(((I-A)*inv_t >> FRAC_W) + A), three-stage
// pipeline sharing one advance enable, with a saturating clipped-channel counter.
module srsc_recover_pipe #(
   parameter int PIX_W  = 8,
   parameter int INV_W  = 8,
   parameter int FRAC_W = 6,
   parameter int CH     = 3,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CH*PIX_W-1:0]   in_pixel,
   input  logic [CH*PIX_W-1:0]   atm_light,
   input  logic [INV_W-1:0]      inv_trans,
   input  logic                  bypass,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CH*PIX_W-1:0]   out_pixel,
   output logic [CNT_W-1:0]      sat_count,
   input  logic                  sat_clr
);
   localparam int DW  = PIX_W + 1;
   localparam int PW  = PIX_W + INV_W + 2;
   localparam int SW  = PW + 1;
   localparam int PCW = $clog2(CH + 1);
   localparam logic [INV_W-1:0] INV_ONE = INV_W'(1) << FRAC_W;

   logic                 en;
   logic                 accept;
   logic                 fire;
   logic                 s1_valid, s2_valid;
   logic                 s1_bypass, s2_bypass;
   logic signed [DW-1:0] s1_diff [CH];
   logic signed [DW-1:0] diff_d  [CH];
   logic [CH*PIX_W-1:0]  s1_atm, s2_atm;
   logic [INV_W-1:0]     s1_inv;
   logic signed [PW-1:0] s2_prod [CH];
   logic signed [PW-1:0] sh_d    [CH];
   logic signed [SW-1:0] sum_d   [CH];
   logic [CH*PIX_W-1:0]  pix_d;
   logic [CH-1:0]        clip_d, s3_clip;
   logic [PCW-1:0]       pop;
   logic [CNT_W:0]       sat_sum;

   assign en       = out_ready | ~out_valid;
   assign in_ready = en;
   assign accept   = in_valid & en;
   assign fire     = out_valid & out_ready;

   always_comb begin
      for (int c = 0; c < CH; c++) begin
         diff_d[c] = $signed({1'b0, in_pixel[c*PIX_W +: PIX_W]})
                   - $signed({1'b0, atm_light[c*PIX_W +: PIX_W]});
      end
   end

   // Floor shift, add A, clamp; the sign bit and the bits above PIX_W select the clip side.
   always_comb begin
      pix_d  = '0;
      clip_d = '0;
      for (int c = 0; c < CH; c++) begin
         sh_d[c]  = s2_prod[c] >>> FRAC_W;
         sum_d[c] = {sh_d[c][PW-1], sh_d[c]}
                  + $signed({{(SW-PIX_W){1'b0}}, s2_atm[c*PIX_W +: PIX_W]});
         if (sum_d[c][SW-1]) begin
            pix_d[c*PIX_W +: PIX_W] = '0;
            clip_d[c]               = 1'b1;
         end else if (|sum_d[c][SW-2:PIX_W]) begin
            pix_d[c*PIX_W +: PIX_W] = '1;
            clip_d[c]               = 1'b1;
         end else begin
            pix_d[c*PIX_W +: PIX_W] = sum_d[c][PIX_W-1:0];
         end
      end
      if (s2_bypass) clip_d = '0;
   end

   always_comb begin
      pop = '0;
      for (int c = 0; c < CH; c++) pop = pop + PCW'(s3_clip[c]);
   end

   assign sat_sum = {1'b0, sat_count} + (CNT_W+1)'(pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_pixel <= '0;
         s3_clip   <= '0;
      end else if (en) begin
         s1_valid  <= accept;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         out_pixel <= pix_d;
         s3_clip   <= clip_d;
      end
   end

   // Bypass beats run the datapath with inv = 1.0, which reproduces I exactly.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int c = 0; c < CH; c++) begin
            s1_diff[c] <= diff_d[c];
            s2_prod[c] <= s1_diff[c] * $signed({1'b0, s1_inv});
         end
         s1_atm    <= atm_light;
         s1_inv    <= bypass ? INV_ONE : inv_trans;
         s1_bypass <= bypass;
         s2_atm    <= s1_atm;
         s2_bypass <= s1_bypass;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)            sat_count <= '0;
      else if (sat_clr)   sat_count <= '0;
      else if (fire)      sat_count <= sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
   end

endmodule

// File: tb/tb_srsc_recover_pipe.sv
// Self-checking bench for srsc_recover_pipe: directed spec vectors plus a
// randomized stream scored against an arithmetic reference model.
module tb_srsc_recover_pipe;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, bypass, out_valid, out_ready, sat_clr;
   logic [23:0] in_pixel, atm_light, out_pixel;
   logic [7:0]  inv_trans;
   logic [15:0] sat_count;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [23:0] exp_q[$];
   int          clip_q[$];

   always #5 clk = ~clk;

   srsc_recover_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_pixel(in_pixel), .atm_light(atm_light), .inv_trans(inv_trans),
      .bypass(bypass), .out_valid(out_valid), .out_ready(out_ready),
      .out_pixel(out_pixel), .sat_count(sat_count), .sat_clr(sat_clr)
   );

   // Reference: per channel floor(((I-A)*inv)/64) + A, clamped to 0..255.
   function automatic void model(input logic [23:0] i_pix, input logic [23:0] a_pix,
                                 input logic [7:0] inv, input logic byp,
                                 output logic [23:0] pix, output int clips);
      int i, a, p, q, j;
      pix   = '0;
      clips = 0;
      for (int c = 0; c < 3; c++) begin
         i = int'(i_pix[c*8 +: 8]);
         a = int'(a_pix[c*8 +: 8]);
         if (byp) begin
            j = i;
         end else begin
            p = (i - a) * int'(inv);
            q = p / 64;
            if (p < 0 && (p % 64) != 0) q = q - 1;
            j = q + a;
            if (j < 0)   begin j = 0;   clips++; end
            if (j > 255) begin j = 255; clips++; end
         end
         pix[c*8 +: 8] = 8'(j);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      bypass    = 1'b0;
      sat_clr   = 1'b0;
      out_ready = 1'b1;
   endtask

   // Sends one beat into an empty pipe; reports latency, output pixel and sat_count change.
   task automatic send_one(input logic [23:0] i_pix, input logic [23:0] a_pix,
                           input logic [7:0] inv, input logic byp,
                           output int lat, output logic [23:0] pix, output int dsat);
      int s0;
      s0        = int'(sat_count);
      in_pixel  = i_pix;
      atm_light = a_pix;
      inv_trans = inv;
      bypass    = byp;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      lat       = 0;
      do begin
         tick();
         in_valid = 1'b0;
         bypass   = 1'b0;
         lat++;
      end while (!out_valid && lat < 10);
      pix = out_pixel;
      if (!out_valid) lat = -1;
      tick();
      dsat = int'(sat_count) - s0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      in_pixel = '0; atm_light = '0; inv_trans = '0;
      tick(); tick();
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
      n_tests++;
      if (sat_count !== 16'd0) begin n_fail++; $display("FAIL reset_sat_count got %0d exp 0", sat_count); end
      n_tests++;
      if (out_pixel !== 24'd0) begin n_fail++; $display("FAIL reset_out_pixel got %h exp 0", out_pixel); end
      rst = 1'b0;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
   endtask

   task automatic test_identity();
      int lat, dsat;
      logic [23:0] pix;
      send_one({8'd250, 8'd128, 8'd10}, {8'd100, 8'd100, 8'd100}, 8'd64, 1'b0, lat, pix, dsat);
      n_tests++;
      if (lat !== 3) begin n_fail++; $display("FAIL identity_latency got %0d exp 3", lat); end
      n_tests++;
      if (pix !== {8'd250, 8'd128, 8'd10}) begin n_fail++; $display("FAIL identity_pixel got %h exp fa800a", pix); end
      n_tests++;
      if (dsat !== 0) begin n_fail++; $display("FAIL identity_sat got %0d exp 0", dsat); end
   endtask

   task automatic test_clamp();
      int lat, dsat;
      logic [23:0] pix;
      send_one({8'd99, 8'd50, 8'd200}, {8'd100, 8'd150, 8'd100}, 8'd192, 1'b0, lat, pix, dsat);
      n_tests++;
      if (pix !== {8'd97, 8'd0, 8'd255}) begin n_fail++; $display("FAIL clamp_pixel got %h exp 6100ff", pix); end
      n_tests++;
      if (dsat !== 2) begin n_fail++; $display("FAIL clamp_sat got %0d exp 2", dsat); end
   endtask

   task automatic test_bypass();
      int lat, dsat;
      logic [23:0] pix;
      send_one({8'd7, 8'd0, 8'd255}, 24'd0, 8'd255, 1'b1, lat, pix, dsat);
      n_tests++;
      if (pix !== {8'd7, 8'd0, 8'd255}) begin n_fail++; $display("FAIL bypass_pixel got %h exp 0700ff", pix); end
      n_tests++;
      if (dsat !== 0) begin n_fail++; $display("FAIL bypass_sat got %0d exp 0", dsat); end
   endtask

   task automatic test_back_pressure();
      logic [23:0] bi[8], ba[8];
      logic [7:0]  bv[8];
      logic [23:0] e_pix, prev_pix;
      logic        prev_stall;
      int          e_clips, sent, got, cyc;
      bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 8; k++) begin
         bi[k] = 24'($urandom()); ba[k] = 24'($urandom()); bv[k] = 8'($urandom());
      end
      exp_q.delete(); clip_q.delete();
      sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_pix = '0;
      while (got < 8 && cyc < 100) begin
         out_ready = pat[cyc % 4];
         in_valid  = (sent < 8);
         if (sent < 8) begin
            in_pixel = bi[sent]; atm_light = ba[sent]; inv_trans = bv[sent];
         end
         #1;
         n_tests++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            n_fail++; $display("FAIL bp_in_ready got %0b ov %0b or %0b", in_ready, out_valid, out_ready);
         end
         if (prev_stall) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_pixel !== prev_pix) begin
               n_fail++; $display("FAIL bp_stall_hold got %0b/%h exp 1/%h", out_valid, out_pixel, prev_pix);
            end
         end
         if (in_valid && in_ready) begin
            model(bi[sent], ba[sent], bv[sent], 1'b0, e_pix, e_clips);
            exp_q.push_back(e_pix); clip_q.push_back(e_clips);
            sent++;
         end
         if (out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL bp_extra_output got %h exp none", out_pixel);
            end else begin
               e_pix = exp_q.pop_front(); void'(clip_q.pop_front());
               if (out_pixel !== e_pix) begin n_fail++; $display("FAIL bp_order got %h exp %h", out_pixel, e_pix); end
            end
            got++;
         end
         prev_stall = out_valid && !out_ready;
         prev_pix   = out_pixel;
         @(posedge clk);
         #1;
         cyc++;
      end
      n_tests++;
      if (got !== 8 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL bp_count got %0d exp 8 (pending %0d)", got, exp_q.size());
      end
      idle();
      repeat (4) tick();
   endtask

   task automatic test_random();
      logic [23:0] e_pix;
      int          e_clips, fired_clips, exp_sat;
      logic        fire;
      idle();
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      exp_sat = 0;
      exp_q.delete(); clip_q.delete();
      for (int cyc = 0; cyc < 450; cyc++) begin
         if (cyc < 400) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            bypass    = ($urandom_range(0, 3) == 0);
            sat_clr   = ($urandom_range(0, 15) == 0);
            in_pixel  = 24'($urandom()); atm_light = 24'($urandom()); inv_trans = 8'($urandom());
         end else begin
            idle();
         end
         #1;
         n_tests++;
         if (sat_count !== 16'(exp_sat)) begin
            n_fail++; $display("FAIL rand_sat_count got %0d exp %0d", sat_count, exp_sat);
         end
         if (in_valid && in_ready) begin
            model(in_pixel, atm_light, inv_trans, bypass, e_pix, e_clips);
            exp_q.push_back(e_pix); clip_q.push_back(e_clips);
         end
         fire = out_valid && out_ready;
         fired_clips = 0;
         if (fire) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rand_extra_output got %h exp none", out_pixel);
            end else begin
               e_pix = exp_q.pop_front(); fired_clips = clip_q.pop_front();
               if (out_pixel !== e_pix) begin n_fail++; $display("FAIL rand_pixel got %h exp %h", out_pixel, e_pix); end
            end
         end
         if (sat_clr) exp_sat = 0;
         else if (fire) exp_sat = (exp_sat + fired_clips > 65535) ? 65535 : exp_sat + fired_clips;
         @(posedge clk);
         #1;
      end
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_lost_beats got %0d pending exp 0", exp_q.size()); end
   endtask

   task automatic test_saturation();
      idle();
      sat_clr = 1'b1;
      tick();
      sat_clr   = 1'b0;
      atm_light = 24'd0;
      inv_trans = 8'd255;
      in_pixel  = 24'hFFFFFF;
      in_valid  = 1'b1;
      repeat (21844) tick();
      in_pixel = 24'h00FFFF;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      n_tests++;
      if (sat_count !== 16'd65534) begin n_fail++; $display("FAIL sat_preload got %0d exp 65534", sat_count); end
      for (int k = 0; k < 2; k++) begin
         in_pixel = 24'hFFFFFF;
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         repeat (4) tick();
         n_tests++;
         if (sat_count !== 16'd65535) begin n_fail++; $display("FAIL sat_hold_%0d got %0d exp 65535", k, sat_count); end
      end
      out_ready = 1'b0;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      n_tests++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_clr_setup out_valid got %0b exp 1", out_valid); end
      out_ready = 1'b1;
      sat_clr   = 1'b1;
      tick();
      sat_clr = 1'b0;
      n_tests++;
      if (sat_count !== 16'd0) begin n_fail++; $display("FAIL sat_clr_priority got %0d exp 0", sat_count); end
   endtask

   task automatic test_reset_midstream();
      int          lat, dsat, stale;
      logic [23:0] pix;
      send_one({8'd99, 8'd50, 8'd200}, {8'd100, 8'd150, 8'd100}, 8'd192, 1'b0, lat, pix, dsat);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_pixel = 24'($urandom());
         tick();
      end
      in_valid = 1'b0;
      n_tests++;
      if (out_valid !== 1'b1 || sat_count !== 16'd2) begin
         n_fail++; $display("FAIL mid_setup got ov %0b sat %0d exp ov 1 sat 2", out_valid, sat_count);
      end
      rst = 1'b1;
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || sat_count !== 16'd0 || in_ready !== 1'b1 || out_pixel !== 24'd0) begin
         n_fail++;
         $display("FAIL mid_reset got ov %0b sat %0d rdy %0b pix %h exp 0 0 1 0", out_valid, sat_count, in_ready, out_pixel);
      end
      rst       = 1'b0;
      out_ready = 1'b1;
      stale     = 0;
      repeat (6) begin
         tick();
         if (out_valid) stale++;
      end
      n_tests++;
      if (stale !== 0) begin n_fail++; $display("FAIL mid_stale_beats got %0d exp 0", stale); end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_clamp();
      test_bypass();
      test_back_pressure();
      test_random();
      test_saturation();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/srsc_recover_pipe.md
SRSC_RECOVER_PIPE -- requirements
Module: srsc_recover_pipe

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning per-channel pixel width (unsigned, Q PIX_W.0).
REQ-002 SHALL have parameter INV_W, default 8, meaning inverse-transmission width (unsigned).
REQ-003 SHALL have parameter FRAC_W, default 6, meaning inverse-transmission fraction bits (Q(INV_W-FRAC_W).FRAC_W); FRAC_W < INV_W.
REQ-004 SHALL have parameter CH, default 3, meaning channel count, with channel 0 in the LSBs.
REQ-005 SHALL have parameter CNT_W, default 16, meaning saturation counter width.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  input beat valid.
REQ-009 in_ready  output  1  block accepts the input beat this cycle.
REQ-010 in_pixel  input  CH*PIX_W  hazy pixel I.
REQ-011 atm_light  input  CH*PIX_W  atmospheric light A, sampled with the beat.
REQ-012 inv_trans  input  INV_W  1/t shared by all channels.
REQ-013 bypass  input  1  per-beat pass-through flag.
REQ-014 out_valid  output  1  output beat valid.
REQ-015 out_ready  input  1  downstream accepts.
REQ-016 out_pixel  output  CH*PIX_W  recovered radiance J.
REQ-017 sat_count  output  CNT_W  clipped-channel count.
REQ-018 sat_clr  input  1  clears sat_count.

Function
REQ-019 Per channel, the block SHALL compute J = clamp(floor(((I-A)*inv_trans) / 2^FRAC_W) + A, 0, 2^PIX_W-1).
REQ-020 Stage 1 SHALL register the signed difference I-A as PIX_W+1 bits, plus A, inv_trans and bypass.
REQ-021 Stage 2 SHALL register the signed product diff * {0,inv_trans} as PIX_W+INV_W+2 bits, with no truncation.
REQ-022 Stage 3 SHALL arithmetic-shift the product right by FRAC_W (round toward minus infinity), add zero-extended A, clamp to [0, 2^PIX_W-1], and register the result together with a per-channel clip flag.
REQ-023 With bypass=1, the out_pixel for that beat SHALL equal its in_pixel exactly, and its clip flags SHALL be 0.
REQ-024 A single advance enable, en = out_ready OR NOT out_valid, SHALL move all three stages together; in_ready SHALL equal en.
REQ-025 An input beat SHALL be accepted only when in_valid AND in_ready; a stage with no beat SHALL carry valid=0 (bubbles are not collapsed).
REQ-026 Latency SHALL be exactly 3 cycles from acceptance to out_valid when out_ready is held high; throughput SHALL be 1 beat per cycle.
REQ-027 While out_valid=1 and out_ready=0, out_pixel and out_valid SHALL hold stable and no internal stage shall change.
REQ-028 When out_valid AND out_ready, sat_count SHALL add the number of set clip flags in that beat (0..CH), saturating at 2^CNT_W-1 with no wrap.
REQ-029 If sat_clr=1, sat_count SHALL become 0 next cycle; this takes priority over a simultaneous increment, whose contribution is discarded.
REQ-030 Changes to atm_light or inv_trans between beats SHALL affect only beats accepted afterwards.

Reset
REQ-031 Under rst, all stage valids, out_valid and sat_count SHALL be 0 and out_pixel SHALL be 0 on the next edge; in-flight beats are dropped.
REQ-032 After reset deasserts, in_ready SHALL be 1 (pipeline empty) in the first cycle.
REQ-033 rst SHALL take priority over sat_clr and over all handshake activity.

Verification (defaults: PIX_W=8, INV_W=8, FRAC_W=6, CH=3)
REQ-034 Identity: I=(10,128,250), A=(100,100,100), inv=64, out_ready=1 -> out (10,128,250) exactly 3 cycles after acceptance, sat_count unchanged.
REQ-035 Clamping: I=(200,50,99), A=(100,150,100), inv=192 (3.0) -> out (255,0,97), sat_count +=2; floor check: ch2 -3/1 gives -1*192>>>6=-3, so 97.
REQ-036 Back-pressure: stream 8 consecutive beats with out_ready toggling 1,0,0,1,... -> all 8 outputs in order, none lost or duplicated, out_pixel stable during stalls, in_ready=0 exactly when out_valid=1 and out_ready=0.
REQ-037 Bypass and counter: bypass=1 beat with I=(255,0,7), A=0, inv=255 -> out (255,0,7), no count; then preload sat_count to 2^16-2 and drive a 3-clip beat -> 65535 held; assert sat_clr in the same cycle as a clip beat -> 0.
REQ-038 Reset mid-stream: assert rst with 3 beats in flight and out_ready=0 -> next cycle out_valid=0, sat_count=0, in_ready=1; no stale beat emerges afterwards.
